magia_tile_stdio_responder: RTL and testbench
=============================================

Name: magia_tile_stdio_responder

Overview:
Synthesizable memory-mapped responder for the tile's print and end-of-computation protocol. Core or testbench software writes characters, an error count and an exit code to fixed word offsets. The block buffers stdout characters in a FIFO and drains them over a valid/ready byte stream. It latches the error count and the EOC/exit code, and exposes both as sideband outputs. It sits behind the tile crossbar as an OBI-style slave decoded at base 0xFFFF_0000.

Parameters:
FIFO_DEPTH, 8, stdout character FIFO depth; power of two, at least 2.
ADDR_WIDTH, 32, request address width; only addr_i[3:2] is decoded.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  request valid
gnt_o  out  1  request granted (combinational)
addr_i  in  ADDR_WIDTH  byte address
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables
wdata_i  in  32  write data
rvalid_o  out  1  response valid
rdata_o  out  32  read data
err_o  out  1  response error, qualified by rvalid_o
char_valid_o  out  1  stdout byte available
char_ready_i  in  1  consumer accepts byte
char_data_o  out  8  stdout byte (FIFO head)
errors_valid_o  out  1  error count has been written
errors_o  out  8  latched error count
eoc_o  out  1  end of computation
exit_code_o  out  31  latched exit code

Behaviour:
- Register map, by addr_i[3:2]:
  - 0 STDERR: write latches wdata_i[7:0] into errors_o and sets errors_valid_o. Read returns {24'b0, errors_o}.
  - 1 STDOUT: write pushes wdata_i[7:0]. Writes with wdata_i == 0 or wdata_i >= 256 are accepted and dropped. Read returns {24'b0, fill level}.
  - 2 EOC: write with wdata_i[31] = 1 sets eoc_o and latches exit_code_o = wdata_i[30:0]. Read returns {eoc_o, exit_code_o}.
  - 3 STATUS (read-only): {29'b0, fifo_full, fifo_empty, eoc_o}. A write returns err_o = 1 and has no side effect.
- Handshake:
  - gnt_o = req_i, except gnt_o = 0 for a STDOUT write while the FIFO is full. Back-pressure is applied; data is never dropped.
  - Exactly one response per grant: rvalid_o is asserted the cycle after the grant, for one cycle, with rdata_o and err_o registered.
  - rdata_o = 0 on writes; rdata_o = 0 whenever rvalid_o = 0.
  - be_i must be 4'hF for all accesses. Any other value returns err_o = 1 with no side effect.
- EOC is sticky:
  - Once eoc_o = 1, further EOC writes are accepted with err_o = 0 and ignored; the first exit code is kept.
  - A write with bit31 = 0 has no effect.
- errors_o: the last STDERR write wins; errors_valid_o stays set.
- FIFO: circular buffer with read/write pointers and a count.
  - char_valid_o = !empty. char_data_o is the head entry, held stable while char_valid_o && !char_ready_i.
  - A pop occurs on char_valid_o && char_ready_i.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is allowed when full, but gnt_o still reflects the registered full flag; no comb path from char_ready_i to gnt_o.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Reset (asynchronous, mid-operation included), all outputs and state cleared:
  - FIFO emptied and pointers zeroed; char_valid_o = 0.
  - rvalid_o = 0, err_o = 0, rdata_o = 0.
  - eoc_o = 0, exit_code_o = 0, errors_o = 0, errors_valid_o = 0.
  - An in-flight response is discarded.
- Latency:
  - Write to STDOUT with the FIFO empty: char_valid_o is asserted the cycle after the grant.
  - Sideband outputs update the cycle after the grant.

Test Plan:
- Reset then idle: all outputs 0. Read STATUS -> rdata_o = 0x2, err_o = 0, rvalid_o asserted 1 cycle after gnt_o.
- Write 0x48, 0x69 to 0xFFFF_0004 with char_ready_i = 1 -> char stream emits 0x48 then 0x69 in order. Write 0x0 and 0x100 -> nothing emitted, err_o = 0.
- Hold char_ready_i = 0 and issue 9 STDOUT writes (FIFO_DEPTH = 8) -> 8 granted, 9th has gnt_o = 0 until one pop, then granted. Bytes drain in order 1..9; STATUS full bit = 1 while full.
- Write 0x3 to 0xFFFF_0000 -> errors_o = 3, errors_valid_o = 1. Then write 0x8000_002A to 0xFFFF_0008 -> eoc_o = 1, exit_code_o = 42. A later write of 0x8000_0007 leaves exit_code_o = 42.
- Write to STATUS, or any access with be_i = 4'h1 -> err_o = 1, no state change.
- Assert rst_ni low with 5 bytes queued and eoc_o = 1 -> everything cleared immediately (asynchronously); after release, STATUS reads 0x2.

Source files
------------

// File: rtl/magia_tile_stdio_responder.sv
// Memory-mapped stdio/EOC responder for a tile: buffers stdout bytes in a FIFO,
// latches the error count and exit code, and answers OBI-style requests.
module magia_tile_stdio_responder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  char_valid_o,
    input  logic                  char_ready_i,
    output logic [7:0]            char_data_o,
    output logic                  errors_valid_o,
    output logic [7:0]            errors_o,
    output logic                  eoc_o,
    output logic [30:0]           exit_code_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        REG_STDERR = 2'd0,
        REG_STDOUT = 2'd1,
        REG_EOC    = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          rvalid_r;
    logic          err_r;
    logic [31:0]   rdata_r;
    logic          errors_valid_r;
    logic [7:0]    errors_r;
    logic          eoc_r;
    logic [30:0]   exit_code_r;

    reg_e          reg_idx_s;
    logic          be_ok_s;
    logic          full_s;
    logic          empty_s;
    logic          gnt_s;
    logic          push_s;
    logic          pop_s;
    logic          wr_ok_s;
    logic          resp_err_s;
    logic [31:0]   rd_data_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^{addr_i[ADDR_WIDTH-1:4], addr_i[1:0]};
    assign reg_idx_s     = reg_e'(addr_i[3:2]);
    assign be_ok_s       = (be_i == 4'hF);
    assign full_s        = (count_r == CW'(FIFO_DEPTH));
    assign empty_s       = (count_r == {CW{1'b0}});

    // Grant depends only on registered FIFO state, never on char_ready_i.
    assign gnt_s   = req_i && !(we_i && (reg_idx_s == REG_STDOUT) && full_s);
    assign wr_ok_s = gnt_s && we_i && be_ok_s;
    assign push_s  = wr_ok_s && (reg_idx_s == REG_STDOUT) &&
                     (wdata_i[31:8] == 24'h0) && (wdata_i[7:0] != 8'h00);
    assign pop_s   = !empty_s && char_ready_i;

    // Error decode for the granted access.
    always_comb begin
        resp_err_s = 1'b0;
        if (!be_ok_s) begin
            resp_err_s = 1'b1;
        end else if (we_i && (reg_idx_s == REG_STATUS)) begin
            resp_err_s = 1'b1;
        end else begin
            resp_err_s = 1'b0;
        end
    end

    // Read-data multiplexer over the four word registers.
    always_comb begin
        rd_data_s = 32'h0;
        case (reg_idx_s)
            REG_STDERR: rd_data_s = {24'h0, errors_r};
            REG_STDOUT: rd_data_s = {{(32-CW){1'b0}}, count_r};
            REG_EOC:    rd_data_s = {eoc_r, exit_code_r};
            REG_STATUS: rd_data_s = {29'h0, full_s, empty_s, eoc_r};
            default:    rd_data_s = 32'h0;
        endcase
    end

    // Single-cycle registered response for every grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 32'h0;
        end else begin
            rvalid_r <= gnt_s;
            err_r    <= gnt_s && resp_err_s;
            rdata_r  <= (gnt_s && !we_i && !resp_err_s) ? rd_data_s : 32'h0;
        end
    end

    // Sideband latches: last error count wins, first exit code sticks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            errors_valid_r <= 1'b0;
            errors_r       <= 8'h00;
            eoc_r          <= 1'b0;
            exit_code_r    <= 31'h0;
        end else begin
            if (wr_ok_s && (reg_idx_s == REG_STDERR)) begin
                errors_valid_r <= 1'b1;
                errors_r       <= wdata_i[7:0];
            end
            if (wr_ok_s && (reg_idx_s == REG_EOC) && wdata_i[31] && !eoc_r) begin
                eoc_r       <= 1'b1;
                exit_code_r <= wdata_i[30:0];
            end
        end
    end

    // Stdout circular buffer; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= wdata_i[7:0];
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    assign gnt_o          = gnt_s;
    assign rvalid_o       = rvalid_r;
    assign err_o          = err_r;
    assign rdata_o        = rdata_r;
    assign char_valid_o   = !empty_s;
    assign char_data_o    = fifo_mem_r[rd_ptr_r];
    assign errors_valid_o = errors_valid_r;
    assign errors_o       = errors_r;
    assign eoc_o          = eoc_r;
    assign exit_code_o    = exit_code_r;

endmodule

// File: tb/tb_magia_tile_stdio_responder.sv
// Scoreboard bench for magia_tile_stdio_responder: expected responses and
// stdout bytes are queued when stimulus is granted and checked on output.
module tb_magia_tile_stdio_responder;

    localparam logic [31:0] A_STDERR = 32'hFFFF_0000;
    localparam logic [31:0] A_STDOUT = 32'hFFFF_0004;
    localparam logic [31:0] A_EOC    = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'hF;
    logic [31:0] wdata = 32'h0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        char_valid;
    logic        char_ready = 1'b0;
    logic [7:0]  char_data;
    logic        errors_valid;
    logic [7:0]  errors;
    logic        eoc;
    logic [30:0] exit_code;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] resp_q[$];
    logic [7:0]  char_q[$];

    magia_tile_stdio_responder #(.FIFO_DEPTH(8), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .char_valid_o(char_valid), .char_ready_i(char_ready),
        .char_data_o(char_data), .errors_valid_o(errors_valid), .errors_o(errors),
        .eoc_o(eoc), .exit_code_o(exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Response and byte-stream monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (resp_q.size() == 0) check("resp_spurious", 64'd1, 64'd0);
            else check("resp", {31'h0, err, rdata}, {31'h0, resp_q.pop_front()});
        end
        if (rst_n && !rvalid) check("rdata_idle", {32'h0, rdata}, 64'h0);
        if (rst_n && char_valid && char_ready) begin
            if (char_q.size() == 0) check("char_spurious", 64'd1, 64'd0);
            else check("char", {56'h0, char_data}, {56'h0, char_q.pop_front()});
        end
    end

    // Issues one access, waits (bounded) for the grant, queues expectations.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
        bit granted = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (gnt) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!granted) begin
            check("gnt_timeout", 64'd0, 64'd1);
        end else begin
            resp_q.push_back({exp_err, exp_rd});
            if (w && !exp_err && b == 4'hF && a[3:2] == 2'd1 && d != 32'h0 && d < 32'h100)
                char_q.push_back(d[7:0]);
            @(posedge clk);
        end
        #1;
        req = 1'b0; we = 1'b0; wdata = 32'h0; be = 4'hF;
    endtask

    task automatic drain();
        @(posedge clk); #1; char_ready = 1'b1;
        for (int i = 0; i < 100 && char_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_done", 64'(char_q.size()), 64'd0);
        check("drain_empty", {63'h0, char_valid}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        check("rst_char_valid", {63'h0, char_valid}, 64'd0);
        check("rst_sideband", {29'h0, errors_valid, errors, eoc, exit_code}, 64'h0);
        check("rst_resp", {31'h0, rvalid, err, rdata}, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h2, 1'b0);

        // Ordered stream and dropped characters.
        @(posedge clk); #1; char_ready = 1'b1;
        access(1'b1, A_STDOUT, 32'h48, 4'hF, 32'h0, 1'b0);
        check("latency_char_valid", {63'h0, char_valid}, 64'd1);
        access(1'b1, A_STDOUT, 32'h69, 4'hF, 32'h0, 1'b0);
        access(1'b1, A_STDOUT, 32'h0, 4'hF, 32'h0, 1'b0);
        access(1'b1, A_STDOUT, 32'h100, 4'hF, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1; check("dropped_empty", {63'h0, char_valid}, 64'd0);
        check("stream_done", 64'(char_q.size()), 64'd0);
        char_ready = 1'b0;

        // Fill the FIFO, then check back-pressure on the ninth byte.
        for (int i = 1; i <= 8; i++) access(1'b1, A_STDOUT, 32'(i), 4'hF, 32'h0, 1'b0);
        access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h4, 1'b0);
        access(1'b0, A_STDOUT, 32'h0, 4'hF, 32'h8, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = A_STDOUT; wdata = 32'h9;
        #1; check("full_gnt0_a", {63'h0, gnt}, 64'd0);
        @(negedge clk); #1; check("full_gnt0_b", {63'h0, gnt}, 64'd0);
        @(posedge clk); #1; char_ready = 1'b1;
        check("full_gnt0_c", {63'h0, gnt}, 64'd0);
        @(posedge clk); #1; char_ready = 1'b0;
        check("gnt_after_pop", {63'h0, gnt}, 64'd1);
        if (gnt) begin
            resp_q.push_back({1'b0, 32'h0});
            char_q.push_back(8'h09);
        end
        @(posedge clk); #1; req = 1'b0; we = 1'b0; wdata = 32'h0;
        drain();
        char_ready = 1'b0;

        // Sideband latches and sticky EOC.
        access(1'b1, A_STDERR, 32'h3, 4'hF, 32'h0, 1'b0);
        check("errors", {55'h0, errors_valid, errors}, {55'h0, 1'b1, 8'h03});
        access(1'b1, A_EOC, 32'h0000_0011, 4'hF, 32'h0, 1'b0);
        check("eoc_bit31_clear", {32'h0, eoc, exit_code}, 64'h0);
        access(1'b1, A_EOC, 32'h8000_002A, 4'hF, 32'h0, 1'b0);
        check("eoc_set", {32'h0, eoc, exit_code}, {32'h0, 1'b1, 31'd42});
        access(1'b1, A_EOC, 32'h8000_0007, 4'hF, 32'h0, 1'b0);
        check("eoc_sticky", {32'h0, eoc, exit_code}, {32'h0, 1'b1, 31'd42});
        access(1'b0, A_EOC, 32'h0, 4'hF, 32'h8000_002A, 1'b0);

        // Error responses without side effects.
        access(1'b1, A_STATUS, 32'hFF, 4'hF, 32'h0, 1'b1);
        access(1'b1, A_STDERR, 32'h55, 4'h1, 32'h0, 1'b1);
        access(1'b1, A_STDOUT, 32'h41, 4'h1, 32'h0, 1'b1);
        access(1'b0, A_STDERR, 32'h0, 4'h1, 32'h0, 1'b1);
        access(1'b0, A_STDERR, 32'h0, 4'hF, 32'h3, 1'b0);
        access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h3, 1'b0);

        // Asynchronous reset with bytes queued and EOC set.
        for (int i = 0; i < 5; i++) access(1'b1, A_STDOUT, 32'h30 + 32'(i), 4'hF, 32'h0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_char_valid", {63'h0, char_valid}, 64'd0);
        check("arst_sideband", {29'h0, errors_valid, errors, eoc, exit_code}, 64'h0);
        check("arst_resp", {31'h0, rvalid, err, rdata}, 64'h0);
        char_q.delete();
        resp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("resp_q_empty", 64'(resp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
